mult_div_unit: RTL

Iterative, parametrised multiply/divide unit with architectural HI/LO registers for the pipelined MIPS core. It is attached to the EX stage. It accepts MULT/MULTU/DIV/DIVU and MTHI/MTLO from ID_EX control, and holds `busy` so the hazard logic stalls IF/ID/EX while an operation is in flight. `hi`/`lo` feed the MFHI/MFLO path. WIDTH generalises the datapath beyond the fixed 32-bit ALU.

---
 rtl/md_pkg.sv | 18 +
 rtl/cond_negate.sv | 12 +
 rtl/mult_div_unit.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/md_pkg.sv
// rtl/md_pkg.sv - op encodings and FSM state type for the multiply/divide unit
package md_pkg;

    localparam logic [2:0] MD_MULT  = 3'd0;
    localparam logic [2:0] MD_MULTU = 3'd1;
    localparam logic [2:0] MD_DIV   = 3'd2;
    localparam logic [2:0] MD_DIVU  = 3'd3;
    localparam logic [2:0] MD_MTHI  = 3'd4;
    localparam logic [2:0] MD_MTLO  = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_FIX  = 2'd3
    } md_state_t;

endpackage

// File: rtl/cond_negate.sv
// rtl/cond_negate.sv - two's complement negate when neg is set
module cond_negate #(
    parameter int W = 32
) (
    input  logic [W-1:0] in_val,
    input  logic         neg,
    output logic [W-1:0] out_val
);

    assign out_val = neg ? (~in_val + W'(1)) : in_val;

endmodule

// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - iterative shift-add multiply / restoring divide with HI/LO
module mult_div_unit
    import md_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    md_state_t                state_q, state_d;
    logic [CNT_W-1:0]         count_q, count_d;
    logic [2*WIDTH-1:0]       acc_q, acc_d;
    logic [WIDTH-1:0]         opnd_q, opnd_d;
    logic                     is_div_q, is_div_d;
    logic                     res_neg_q, res_neg_d;
    logic                     rem_neg_q, rem_neg_d;
    logic [WIDTH-1:0]         hi_q, hi_d, lo_q, lo_d;
    logic                     busy_q, busy_d, done_q, done_d;

    logic                     signed_op;
    logic [WIDTH-1:0]         abs_a, abs_b;
    logic [2*WIDTH-1:0]       prod_fix;
    logic [WIDTH-1:0]         quo_fix, rem_fix;

    // Signed ops (MULT/DIV) have op[0] clear
    assign signed_op = ~op[0];

    cond_negate #(.W(WIDTH)) u_abs_a (
        .in_val (src_a), .neg (signed_op & src_a[WIDTH-1]), .out_val (abs_a));
    cond_negate #(.W(WIDTH)) u_abs_b (
        .in_val (src_b), .neg (signed_op & src_b[WIDTH-1]), .out_val (abs_b));
    cond_negate #(.W(2*WIDTH)) u_prod_fix (
        .in_val (acc_q), .neg (res_neg_q), .out_val (prod_fix));
    cond_negate #(.W(WIDTH)) u_quo_fix (
        .in_val (acc_q[WIDTH-1:0]), .neg (res_neg_q), .out_val (quo_fix));
    cond_negate #(.W(WIDTH)) u_rem_fix (
        .in_val (acc_q[2*WIDTH-1:WIDTH]), .neg (rem_neg_q), .out_val (rem_fix));

    // Multiply: acc = {partial product, remaining multiplier bits}
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    // Divide: acc = {partial remainder, dividend bits shifting into quotient}
    logic [WIDTH:0]     rem_shift;
    logic               div_ge;
    logic [WIDTH-1:0]   rem_new;
    logic [2*WIDTH-1:0] div_next;

    always_comb begin
        mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? opnd_q : '0)};
        mul_next  = {mul_sum, acc_q[WIDTH-1:1]};
        rem_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        div_ge    = rem_shift >= {1'b0, opnd_q};
        // When div_ge holds the true difference is below the divisor, so WIDTH bits suffice
        rem_new   = div_ge ? (rem_shift[WIDTH-1:0] - opnd_q) : rem_shift[WIDTH-1:0];
        div_next  = {rem_new, acc_q[WIDTH-2:0], div_ge};
    end

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        acc_d     = acc_q;
        opnd_d    = opnd_q;
        is_div_d  = is_div_q;
        res_neg_d = res_neg_q;
        rem_neg_d = rem_neg_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        busy_d    = busy_q;
        done_d    = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start && !flush) begin
                    if (!op[2]) begin
                        is_div_d  = op[1];
                        opnd_d    = op[1] ? abs_b : abs_a;
                        acc_d     = {{WIDTH{1'b0}}, (op[1] ? abs_a : abs_b)};
                        res_neg_d = signed_op & (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
                        rem_neg_d = signed_op & src_a[WIDTH-1];
                        count_d   = '0;
                        state_d   = op[1] ? ST_DIV : ST_MUL;
                        busy_d    = 1'b1;
                    end else if (op == MD_MTHI) begin
                        hi_d = src_a;
                    end else if (op == MD_MTLO) begin
                        lo_d = src_a;
                    end
                end
            end
            ST_MUL, ST_DIV: begin
                acc_d = (state_q == ST_DIV) ? div_next : mul_next;
                if (flush) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end else if (count_q == CNT_W'(WIDTH - 1)) begin
                    state_d = ST_FIX;
                end else begin
                    count_d = count_q + CNT_W'(1);
                end
            end
            ST_FIX: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
                if (!flush) begin
                    if (is_div_q) begin
                        hi_d = rem_fix;
                        lo_d = quo_fix;
                    end else begin
                        {hi_d, lo_d} = prod_fix;
                    end
                    done_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            count_q   <= '0;
            acc_q     <= '0;
            opnd_q    <= '0;
            is_div_q  <= 1'b0;
            res_neg_q <= 1'b0;
            rem_neg_q <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            acc_q     <= acc_d;
            opnd_q    <= opnd_d;
            is_div_q  <= is_div_d;
            res_neg_q <= res_neg_d;
            rem_neg_q <= rem_neg_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule
